// File: rtl/usb_ctrl_rdonly.sv
// usb_ctrl_rdonly: read-only slave-FIFO controller for the CYUSB3014.
// Issues bursts of reads and forwards words through a 4-entry skid buffer.
`timescale 1ns/1ps
module usb_ctrl_rdonly #(
  parameter int pack_len = 256,
  parameter int RD_LAT   = 2
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic [31:0] data,
  input  logic        flaga,
  input  logic        flagb,
  input  logic        flagc,
  input  logic        flagd,
  output logic        slcs_n,
  output logic        slrd_n,
  output logic        sloe_n,
  output logic        slwr_n,
  output logic        pktend_n,
  output logic [1:0]  a,
  output logic        pclk,
  output logic [31:0] dataOUT,
  output logic        dout_vld,
  output logic        dout_last,
  input  logic        dout_rdy
);

  localparam logic [3:0] S_REST   = 4'd0;
  localparam logic [3:0] S_IDLE   = 4'd1;
  localparam logic [3:0] S_READ   = 4'd2;
  localparam logic [3:0] S_RDELAY = 4'd3;
  localparam logic [3:0] S_RSTOP  = 4'd4;

  localparam logic [8:0] PLEN = 9'(pack_len);

  logic [3:0]        state, state_nx;
  logic [8:0]        rd_cnt;
  logic [2:0]        delay_cnt, dly_nx;
  logic [RD_LAT-1:0] pv, pl, mpipe;
  logic [31:0]       mem [4];
  logic [3:0]        mlast;
  logic [1:0]        wp, rp;
  logic [2:0]        cnt;
  logic [8:0]        inflight;
  logic              rd_low, issue, rd_exit, mark, mskid;
  logic              push, push_last, pop, sel_on;
  logic              unused_flags;

  assign unused_flags = flaga ^ flagb;
  assign slwr_n   = 1'b1;
  assign pktend_n = 1'b1;
  assign pclk     = clk;

  assign rd_low   = !slrd_n;
  assign dout_vld = (cnt != 3'd0);
  assign pop      = dout_vld & dout_rdy;
  assign dataOUT  = mem[rp];
  assign dly_nx   = delay_cnt + 3'd1;

  // Reads whose word has not yet landed in the skid buffer
  always_comb begin
    inflight = {8'd0, rd_low};
    for (int i = 0; i < RD_LAT; i++)
      inflight = inflight + {8'd0, pv[i]};
  end

  assign issue = (state == S_READ) & flagc & flagd & dout_rdy
               & (rd_cnt < PLEN)
               & (({6'd0, cnt} + inflight) <= 9'd3);
  assign rd_exit = (state == S_READ)
                 & ((rd_cnt >= PLEN) | !flagc | !flagd);
  assign mark = rd_exit & (rd_cnt != 9'd0);

  // On exit, tag the youngest outstanding read as the last of the burst
  always_comb begin
    logic seen;
    seen  = rd_low;
    mpipe = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      if (pv[i] && !seen) begin
        mpipe[i] = mark;
        seen     = 1'b1;
      end
    end
    mskid = mark & !seen & (cnt != 3'd0);
  end

  assign push      = pv[RD_LAT-1];
  assign push_last = pl[RD_LAT-1] | mpipe[RD_LAT-1];
  assign dout_last = dout_vld
                   & (mlast[rp] | (mskid & (cnt == 3'd1)));

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      S_REST:   state_nx = S_IDLE;
      S_IDLE:   if (flagc && dout_rdy && cnt == 3'd0)
                  state_nx = S_READ;
      S_READ:   if (rd_exit) state_nx = S_RDELAY;
      S_RDELAY: if (inflight == 9'd0) state_nx = S_RSTOP;
      S_RSTOP:  if (dly_nx >= 3'd4) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign sel_on = (state_nx == S_READ) | (state_nx == S_RDELAY);

  // State, counters and registered bus strobes
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= S_REST;
      slcs_n    <= 1'b1;
      slrd_n    <= 1'b1;
      sloe_n    <= 1'b1;
      a         <= 2'b00;
      rd_cnt    <= '0;
      delay_cnt <= '0;
    end else begin
      state  <= state_nx;
      slcs_n <= !sel_on;
      sloe_n <= !sel_on;
      slrd_n <= !issue;
      a      <= 2'b11;
      if (state == S_IDLE) rd_cnt <= '0;
      else if (issue)      rd_cnt <= rd_cnt + 9'd1;
      if (state == S_RSTOP) delay_cnt <= dly_nx;
      else                  delay_cnt <= '0;
    end
  end

  // Read-tag pipeline matching the FIFO read latency
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      pv <= '0;
      pl <= '0;
    end else begin
      pv[0] <= rd_low;
      pl[0] <= rd_low & mark;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1] | mpipe[i-1];
      end
    end
  end

  // Four-entry skid buffer between the bus and downstream
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      mlast <= '0;
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
    end else begin
      if (push) begin
        mem[wp]   <= data;
        mlast[wp] <= push_last;
        wp        <= wp + 2'd1;
      end
      if (mskid) mlast[wp - 2'd1] <= 1'b1;
      if (pop) rp <= rp + 2'd1;
      cnt <= cnt + {2'd0, push} - {2'd0, pop};
    end
  end

  // A push into a full buffer means the issue throttle is broken
  always_ff @(posedge clk) begin
    if (res_n)
      assert (!(push && cnt == 3'd4))
        else $error("skid buffer overflow");
  end

endmodule

// File: doc/usb_ctrl_rdonly.md
USB_CTRL_RDONLY -- requirements
Module: usb_ctrl_rdOnly

Interface
REQ-001 SHALL have parameter pack_len, default 256, max words per read burst (range 1..256).
REQ-002 SHALL have parameter RD_LAT, default 2, cycles from slrd_n low at a clk edge to the word valid on data at a clk edge.
REQ-003 clk  in  1  system clock; one clock domain; asynchronous active-low reset.
REQ-004 res_n  in  1  asynchronous active-low reset.
REQ-005 data  in  32  FIFO data from the CYUSB3014 (read-only bus).
REQ-006 flaga, flagb  in  1 each  write flags; unused, ignored.
REQ-007 flagc  in  1  read status: 1 = data available, 0 = empty.
REQ-008 flagd  in  1  read almost-empty: 1 = more than 6 bytes left, 0 = 6 bytes or fewer.
REQ-009 slcs_n, slrd_n, sloe_n  out  1 each  chip select, read enable and output enable; all active-low, registered.
REQ-010 slwr_n, pktend_n  out  1 each  write enable and packet end; held 1 at all times.
REQ-011 a  out  2  socket address; registered.
REQ-012 pclk  out  1  equal to clk.
REQ-013 dataOUT  out  32  downstream word.
REQ-014 dout_vld  out  1  dataOUT valid.
REQ-015 dout_last  out  1  last word of the burst; qualified by dout_vld.
REQ-016 dout_rdy  in  1  downstream accepts the word when dout_vld && dout_rdy.

Function
REQ-017 States SHALL be Rest, Idle, Read, Rdelay and Read_stop, held in a 4-bit state register.
REQ-018 Rest SHALL go to Idle unconditionally after one cycle.
REQ-019 Idle SHALL drive a=2'b11 and all sl* high, and SHALL go to Read when flagc=1, dout_rdy=1 and the skid buffer is empty.
REQ-020 Read SHALL drive slcs_n=0 and sloe_n=0.
REQ-021 Read SHALL drive slrd_n=0 in a cycle only when issue=1, where issue = flagc & flagd & dout_rdy & (rd_cnt<pack_len) & (occupancy+inflight<=3).
REQ-022 rd_cnt (9-bit) SHALL increment per issued read and clear in Idle.
REQ-023 Read SHALL go to Rdelay when rd_cnt reaches pack_len, or when flagc=0 or flagd=0.
REQ-024 dout_rdy=0 SHALL only pause issuing; it SHALL NOT leave Read.
REQ-025 Each issued read SHALL carry a tag through an RD_LAT-deep pipeline; the word on data SHALL be captured into the skid buffer RD_LAT cycles later.
REQ-026 The tag SHALL mark last=1 on the final read issued before Read exits.
REQ-027 Rdelay SHALL hold slrd_n=1, slcs_n=0 and sloe_n=0 until inflight=0, then go to Read_stop.
REQ-028 Read_stop SHALL drive all sl* high and count delay_cnt 0..4; at delay_cnt>=4 it SHALL go to Idle.
REQ-029 The skid buffer SHALL be a 4-entry FIFO; dout_vld SHALL equal "not empty"; dataOUT and dout_last SHALL show the head entry.
REQ-030 The skid buffer SHALL pop on dout_vld && dout_rdy.
REQ-031 Push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-032 The skid buffer SHALL never overflow; a push when full is a design error and SHALL be asserted in simulation.
REQ-033 When pack_len words are read, the word with rd_cnt=pack_len-1 SHALL carry dout_last=1.
REQ-034 A short burst (flag-terminated) SHALL carry dout_last=1 on its final word.
REQ-035 An unknown state value SHALL go to Idle.

Reset
REQ-036 During reset, all sl* and pktend_n SHALL be 1, a=2'b00, state=Rest, and counters, pipeline and skid buffer SHALL be cleared.
REQ-037 During reset, dout_vld=0, dout_last=0 and dataOUT=0.
REQ-038 Reset asserted mid-Read SHALL take effect asynchronously: slrd_n=1 immediately and in-flight words discarded.

Verification
REQ-039 Full burst: flagc=flagd=1, dout_rdy=1, model returns 0..255 -> 256 words 0..255 in order; dout_last only on 255; slrd_n low exactly 256 cycles.
REQ-040 Early stop: flagd drops after 10 issued reads -> exactly 10 words out, last on word 9, then Rdelay, Read_stop (4 cycles) and Idle.
REQ-041 Backpressure: dout_rdy toggles 1 cycle on / 2 off over a full burst -> no overflow, no loss or duplication, 256 words in order.
REQ-042 Empty FIFO: flagc=0 for 100 cycles -> slrd_n, slcs_n and sloe_n stay 1, and dout_vld=0.
REQ-043 Reset pulse during a burst at word 50 -> outputs at reset values within the same cycle; a following burst starts from Rest with a clean count.
REQ-044 Static check: slwr_n=1 and pktend_n=1 throughout; a=2'b11 whenever slcs_n=0.
